// File: rtl/wb_stage.sv
// Writeback stage: load extraction, 32x32 integer register file with
// same-cycle write-through bypass, scoreboard release pulse and retire counter.
module wb_stage #(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     mem_wb_ir,
  input  logic [XLEN-1:0] mem_wb_alu,
  input  logic [XLEN-1:0] mem_wb_ldata,
  input  logic            mem_wb_load,
  input  logic            mem_wb_regdest,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            sb_clr_valid,
  output logic [4:0]      sb_clr_rd,
  output logic [63:0]     instret
);

  localparam int NPORTS = 2;

  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;
  logic            retire;

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            sb_clr_valid_q, sb_clr_valid_d;
  logic [4:0]      sb_clr_rd_q, sb_clr_rd_d;
  logic [63:0]     instret_q, instret_d;

  logic [NPORTS-1:0][4:0]      rs_addr;
  logic [NPORTS-1:0][XLEN-1:0] rs_data;

  assign rd     = mem_wb_ir[11:7];
  assign funct3 = mem_wb_ir[14:12];
  assign off    = mem_wb_alu[1:0];

  always_comb begin
    ld_byte = 8'h00;
    case (off)
      2'd0: ld_byte = mem_wb_ldata[7:0];
      2'd1: ld_byte = mem_wb_ldata[15:8];
      2'd2: ld_byte = mem_wb_ldata[23:16];
      2'd3: ld_byte = mem_wb_ldata[31:24];
      default: ld_byte = 8'h00;
    endcase
    // halfword select ignores alu[0]; misaligned halves are not split
    ld_half = mem_wb_alu[1] ? mem_wb_ldata[31:16] : mem_wb_ldata[15:0];
  end

  always_comb begin
    ld_ext = mem_wb_ldata;
    case (funct3)
      3'b000: ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101: ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_wb_ldata;
    endcase
  end

  assign wb_en   = mem_wb_regdest && (rd != 5'd0);
  assign wb_rd   = rd;
  assign wb_data = mem_wb_load ? ld_ext : mem_wb_alu;
  assign retire  = (mem_wb_ir != 32'h0) && (mem_wb_ir != NOP_INST);

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;
  assign rs1_data   = rs_data[0];
  assign rs2_data   = rs_data[1];

  // x0 is forced to zero on read; wb_en already excludes it from writes/bypass
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      if (rs_addr[p] == 5'd0)
        rs_data[p] = '0;
      else if (wb_en && (rs_addr[p] == wb_rd))
        rs_data[p] = wb_data;
      else
        rs_data[p] = rf_q[rs_addr[p]];
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_rd] = wb_data;
    sb_clr_valid_d = wb_en;
    sb_clr_rd_d    = rd;
    instret_d      = instret_q + {63'd0, retire};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      sb_clr_valid_q <= 1'b0;
      sb_clr_rd_q    <= 5'd0;
      instret_q      <= 64'd0;
    end else begin
      rf_q           <= rf_d;
      sb_clr_valid_q <= sb_clr_valid_d;
      sb_clr_rd_q    <= sb_clr_rd_d;
      instret_q      <= instret_d;
    end
  end

  assign sb_clr_valid = sb_clr_valid_q;
  assign sb_clr_rd    = sb_clr_rd_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset state, bypass, load extraction,
// x0 handling, retire counting and asynchronous reset during a write.
module tb_wb_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic [31:0] mem_wb_ir, mem_wb_alu, mem_wb_ldata;
  logic        mem_wb_load, mem_wb_regdest;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_en, sb_clr_valid;
  logic [4:0]  wb_rd, sb_clr_rd;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .mem_wb_ir(mem_wb_ir), .mem_wb_alu(mem_wb_alu), .mem_wb_ldata(mem_wb_ldata),
    .mem_wb_load(mem_wb_load), .mem_wb_regdest(mem_wb_regdest),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .sb_clr_valid(sb_clr_valid), .sb_clr_rd(sb_clr_rd), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd0, f3, rd, op};
  endfunction

  task automatic drive(input logic [31:0] ir, input logic [31:0] alu, input logic load,
                       input logic regdest);
    @(negedge clk);
    mem_wb_ir      = ir;
    mem_wb_alu     = alu;
    mem_wb_load    = load;
    mem_wb_regdest = regdest;
    #1;
  endtask

  task automatic bubble();
    drive(NOP, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    mem_wb_ir = NOP; mem_wb_alu = '0; mem_wb_ldata = 32'h80FF7F01;
    mem_wb_load = 1'b0; mem_wb_regdest = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    #12;
    check("rst_instret", instret, 64'd0);
    check("rst_sbv", {63'd0, sb_clr_valid}, 64'd0);
    check("rst_sbrd", {59'd0, sb_clr_rd}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      check("rst_rs1", {32'd0, rs1_data}, 64'd0);
      check("rst_rs2", {32'd0, rs2_data}, 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // ADDI x5 with bypass, then array read and scoreboard release
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    drive(mk_ir(12'h0, 3'b000, 5'd5, 7'h13), 32'hDEADBEEF, 1'b0, 1'b1);
    check("alu_bypass", {32'd0, rs1_data}, 64'hDEADBEEF);
    check("alu_wb_en", {63'd0, wb_en}, 64'd1);
    check("alu_wb_rd", {59'd0, wb_rd}, 64'd5);
    check("alu_other", {32'd0, rs2_data}, 64'd0);
    check("alu_sbv_early", {63'd0, sb_clr_valid}, 64'd0);
    bubble();
    check("alu_array", {32'd0, rs1_data}, 64'hDEADBEEF);
    check("alu_sbv", {63'd0, sb_clr_valid}, 64'd1);
    check("alu_sbrd", {59'd0, sb_clr_rd}, 64'd5);
    check("alu_instret", instret, 64'd1);
    bubble();
    check("sbv_pulse", {63'd0, sb_clr_valid}, 64'd0);

    // load extraction, ldata = 80FF7F01
    drive(mk_ir(12'h0, 3'b000, 5'd6, 7'h03), 32'h00001003, 1'b1, 1'b1);
    check("lb_off3", {32'd0, wb_data}, 64'hFFFFFF80);
    drive(mk_ir(12'h0, 3'b100, 5'd7, 7'h03), 32'h00001003, 1'b1, 1'b1);
    check("lbu_off3", {32'd0, wb_data}, 64'h00000080);
    drive(mk_ir(12'h0, 3'b001, 5'd8, 7'h03), 32'h00001002, 1'b1, 1'b1);
    check("lh_hi", {32'd0, wb_data}, 64'hFFFF80FF);
    drive(mk_ir(12'h0, 3'b101, 5'd9, 7'h03), 32'h00001000, 1'b1, 1'b1);
    check("lhu_lo", {32'd0, wb_data}, 64'h00007F01);
    drive(mk_ir(12'h0, 3'b010, 5'd10, 7'h03), 32'h00001000, 1'b1, 1'b1);
    check("lw", {32'd0, wb_data}, 64'h80FF7F01);
    drive(mk_ir(12'h0, 3'b000, 5'd12, 7'h03), 32'h00001001, 1'b1, 1'b0);
    check("lb_off1", {32'd0, wb_data}, 64'h0000007F);
    check("lb_nodest_en", {63'd0, wb_en}, 64'd0);
    bubble();
    rs1_addr = 5'd6; rs2_addr = 5'd7; #1;
    check("rd_x6", {32'd0, rs1_data}, 64'hFFFFFF80);
    check("rd_x7", {32'd0, rs2_data}, 64'h00000080);
    rs1_addr = 5'd8; rs2_addr = 5'd9; #1;
    check("rd_x8", {32'd0, rs1_data}, 64'hFFFF80FF);
    check("rd_x9", {32'd0, rs2_data}, 64'h00007F01);
    rs1_addr = 5'd10; rs2_addr = 5'd12; #1;
    check("rd_x10", {32'd0, rs1_data}, 64'h80FF7F01);
    check("rd_x12_nowrite", {32'd0, rs2_data}, 64'd0);
    check("ld_instret", instret, 64'd7);

    // back-to-back writes to x5, last wins
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    drive(mk_ir(12'h1, 3'b000, 5'd5, 7'h13), 32'h11111111, 1'b0, 1'b1);
    check("b2b_first", {32'd0, rs1_data}, 64'h11111111);
    drive(mk_ir(12'h2, 3'b000, 5'd5, 7'h13), 32'h22222222, 1'b0, 1'b1);
    check("b2b_second", {32'd0, rs2_data}, 64'h22222222);
    bubble();
    check("b2b_array", {32'd0, rs1_data}, 64'h22222222);

    // write to x0 is discarded
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    drive(mk_ir(12'h234, 3'b000, 5'd0, 7'h13), 32'h00001234, 1'b0, 1'b1);
    check("x0_wb_en", {63'd0, wb_en}, 64'd0);
    check("x0_bypass", {32'd0, rs1_data}, 64'd0);
    bubble();
    check("x0_sbv", {63'd0, sb_clr_valid}, 64'd0);
    check("x0_read", {32'd0, rs2_data}, 64'd0);
    check("x0_instret", instret, 64'd10);

    // 10 cycles: 4 NOP, 1 zero, 5 real
    drive(32'h00000033, 32'h0, 1'b0, 1'b0);
    drive(NOP, 32'h0, 1'b0, 1'b0);
    drive(32'h00000000, 32'h0, 1'b0, 1'b0);
    drive(32'h00100093, 32'h0, 1'b0, 1'b0);
    drive(NOP, 32'h0, 1'b0, 1'b0);
    drive(32'h00208133, 32'h0, 1'b0, 1'b0);
    drive(NOP, 32'h0, 1'b0, 1'b0);
    drive(32'h00000013 | 32'h00100000, 32'h0, 1'b0, 1'b0);
    drive(NOP, 32'h0, 1'b0, 1'b0);
    drive(32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    bubble();
    check("retire_cnt", instret, 64'd15);

    // async reset between edges while a write is pending
    rs1_addr = 5'd11; rs2_addr = 5'd10;
    drive(mk_ir(12'h0, 3'b000, 5'd11, 7'h13), 32'hCAFEF00D, 1'b0, 1'b1);
    check("ar_bypass", {32'd0, rs1_data}, 64'hCAFEF00D);
    #2;
    reset = 1'b0;
    #1;
    check("ar_instret", instret, 64'd0);
    check("ar_sbv", {63'd0, sb_clr_valid}, 64'd0);
    check("ar_x10", {32'd0, rs2_data}, 64'd0);
    rs2_addr = 5'd5; #1;
    check("ar_x5", {32'd0, rs2_data}, 64'd0);
    bubble();
    check("ar_x11_held", {32'd0, rs1_data}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bubble();
    check("ar_x11_lost", {32'd0, rs1_data}, 64'd0);
    check("ar_x5_lost", {32'd0, rs2_data}, 64'd0);
    check("ar_instret_post", instret, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
